// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter that shares one PicoRV32-style slave port among NUM_REQ requesters.
// A grant is held until the slave returns ready, the watchdog expires, or the owner withdraws its request.
module mem_bus_arbiter #(
   parameter int                    NUM_REQ        = 2,
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    TIMEOUT_CYCLES = 256,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA       = DATA_WIDTH'(32'hDEAD_BEEF)
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_REQ-1:0]                req_valid,
   output logic [NUM_REQ-1:0]                req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_wstrb,
   output logic [DATA_WIDTH-1:0]             req_rdata,
   output logic                              s_valid,
   output logic                              s_write,
   output logic [ADDR_WIDTH-1:0]             s_addr,
   output logic [DATA_WIDTH-1:0]             s_wdata,
   output logic [DATA_WIDTH/8-1:0]           s_wstrb,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   input  logic                              s_ready,
   output logic [$clog2(NUM_REQ)-1:0]        grant_id,
   output logic                              busy,
   output logic                              timeout_err
);

   localparam int          IdW       = $clog2(NUM_REQ);
   localparam int          StrbW     = DATA_WIDTH / 8;
   localparam bit          WdEnable  = (TIMEOUT_CYCLES != 0);
   localparam logic [31:0] WdLimit   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [IdW-1:0] LastId = IdW'(NUM_REQ - 1);

   typedef enum logic {
      IDLE,
      BUSY
   } arbState_t;

   arbState_t          state;
   arbState_t          nextState;
   logic [IdW-1:0]     lastPtr;
   logic [IdW-1:0]     pickId;
   logic [IdW-1:0]     candId;
   logic               pickFound;
   logic               grantValid;
   logic [ADDR_WIDTH-1:0] grantAddr;
   logic [DATA_WIDTH-1:0] grantWdata;
   logic [StrbW-1:0]   grantStrb;
   logic [31:0]        wdCount;
   logic               timeoutHit;

   // Scan upward from the requester after the last owner, wrapping at NUM_REQ,
   // so the previous winner is considered last.
   always_comb begin
      pickId    = '0;
      pickFound = 1'b0;
      candId    = lastPtr;
      for (int k = 0; k < NUM_REQ; k++) begin
         candId = (candId == LastId) ? '0 : candId + 1'b1;
         if (!pickFound && req_valid[candId]) begin
            pickFound = 1'b1;
            pickId    = candId;
         end
      end
   end

   // Select the granted requester's fields; a loop compare avoids multiplying grant_id.
   always_comb begin
      grantValid = 1'b0;
      grantAddr  = '0;
      grantWdata = '0;
      grantStrb  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id == IdW'(i)) begin
            grantValid = req_valid[i];
            grantAddr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            grantWdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            grantStrb  = req_wstrb[i*StrbW +: StrbW];
         end
      end
   end

   assign timeoutHit = WdEnable && (wdCount == WdLimit);
   assign busy       = (state == BUSY);

   // Next-state and output decode; in BUSY a withdrawn request beats s_ready, which beats the watchdog.
   always_comb begin
      nextState   = state;
      s_valid     = 1'b0;
      s_write     = 1'b0;
      s_addr      = '0;
      s_wdata     = '0;
      s_wstrb     = '0;
      req_ready   = '0;
      req_rdata   = '0;
      timeout_err = 1'b0;
      case (state)
         IDLE: begin
            if (pickFound) begin
               nextState = BUSY;
            end
         end
         BUSY: begin
            if (!grantValid) begin
               nextState = IDLE;
            end else if (s_ready) begin
               s_valid             = 1'b1;
               req_ready[grant_id] = 1'b1;
               req_rdata           = s_rdata;
               nextState           = IDLE;
            end else if (timeoutHit) begin
               req_ready[grant_id] = 1'b1;
               req_rdata           = ERR_DATA;
               timeout_err         = 1'b1;
               nextState           = IDLE;
            end else begin
               s_valid = 1'b1;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
      if (s_valid) begin
         s_addr  = grantAddr;
         s_wdata = grantWdata;
         s_wstrb = grantStrb;
         s_write = |grantStrb;
      end
   end

   // State, ownership and watchdog registers; the watchdog restarts on every new grant and saturates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         grant_id <= '0;
         lastPtr  <= LastId;
         wdCount  <= '0;
      end else begin
         state <= nextState;
         if (state == IDLE && pickFound) begin
            grant_id <= pickId;
            lastPtr  <= pickId;
            wdCount  <= '0;
         end else if (state == BUSY && wdCount != '1) begin
            wdCount <= wdCount + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter against a transaction-level round-robin model.
// Each transaction's slave latency is chosen up front, so the bench knows how it must end.
module tb_mem_bus_arbiter;

   localparam int          NumReq  = 3;
   localparam int          AddrW   = 32;
   localparam int          DataW   = 32;
   localparam int          StrbW   = DataW / 8;
   localparam int          IdW     = $clog2(NumReq);
   localparam int          Tmo     = 8;
   localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

   logic                       clk;
   logic                       reset;
   logic [NumReq-1:0]          req_valid;
   logic [NumReq-1:0]          req_ready;
   logic [NumReq*AddrW-1:0]    req_addr;
   logic [NumReq*DataW-1:0]    req_wdata;
   logic [NumReq*StrbW-1:0]    req_wstrb;
   logic [DataW-1:0]           req_rdata;
   logic                       s_valid;
   logic                       s_write;
   logic [AddrW-1:0]           s_addr;
   logic [DataW-1:0]           s_wdata;
   logic [StrbW-1:0]           s_wstrb;
   logic [DataW-1:0]           s_rdata;
   logic                       s_ready;
   logic [IdW-1:0]             grant_id;
   logic                       busy;
   logic                       timeout_err;

   mem_bus_arbiter #(
      .NUM_REQ        (NumReq),
      .ADDR_WIDTH     (AddrW),
      .DATA_WIDTH     (DataW),
      .TIMEOUT_CYCLES (Tmo),
      .ERR_DATA       (ErrData)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_wstrb   (req_wstrb),
      .req_rdata   (req_rdata),
      .s_valid     (s_valid),
      .s_write     (s_write),
      .s_addr      (s_addr),
      .s_wdata     (s_wdata),
      .s_wstrb     (s_wstrb),
      .s_rdata     (s_rdata),
      .s_ready     (s_ready),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   // 10-unit clock; inputs change on the falling edge, outputs are sampled 1 unit later.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Requester side: which requesters are asking and with what fields.
   bit   [NumReq-1:0]  pending;
   logic [AddrW-1:0]   pAddr  [NumReq];
   logic [DataW-1:0]   pWdata [NumReq];
   logic [StrbW-1:0]   pWstrb [NumReq];

   // Reference model: current transaction owner, how many BUSY cycles it has had, its slave latency.
   bit mBusy;
   int mOwner;
   int mLast;
   int mGrant;
   int mCycle;
   int mLat;
   int reqPct;
   int latMax;

   int checks;
   int errors;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   task automatic newRequest(input int i);
      pAddr[i]   = $urandom;
      pWdata[i]  = $urandom;
      pWstrb[i]  = ($urandom_range(0, 1) == 0) ? '0 : StrbW'($urandom);
      pending[i] = 1'b1;
   endtask

   task automatic applyStimulus();
      for (int i = 0; i < NumReq; i++) begin
         req_valid[i]                 = pending[i];
         req_addr[i*AddrW +: AddrW]   = pAddr[i];
         req_wdata[i*DataW +: DataW]  = pWdata[i];
         req_wstrb[i*StrbW +: StrbW]  = pWstrb[i];
      end
      s_ready = mBusy && pending[mOwner] && (mCycle == mLat);
      s_rdata = $urandom;
   endtask

   // Expected outputs for the current cycle from the transaction the model is in.
   task automatic expectCycle();
      logic [NumReq-1:0] eReady;
      logic              eValid;
      logic              eTerr;
      logic [DataW-1:0]  eRdata;
      logic [AddrW-1:0]  eAddr;
      logic [DataW-1:0]  eWdata;
      logic [StrbW-1:0]  eStrb;
      eReady = '0;
      eValid = 1'b0;
      eTerr  = 1'b0;
      eRdata = '0;
      eAddr  = '0;
      eWdata = '0;
      eStrb  = '0;
      if (mBusy && pending[mOwner]) begin
         if (mCycle == mLat) begin
            eValid         = 1'b1;
            eReady[mOwner] = 1'b1;
            eRdata         = s_rdata;
         end else if (mCycle == Tmo) begin
            eReady[mOwner] = 1'b1;
            eRdata         = ErrData;
            eTerr          = 1'b1;
         end else begin
            eValid = 1'b1;
         end
         if (eValid) begin
            eAddr  = pAddr[mOwner];
            eWdata = pWdata[mOwner];
            eStrb  = pWstrb[mOwner];
         end
      end
      checkOutput("busy",        64'(busy),        64'(mBusy));
      checkOutput("grant_id",    64'(grant_id),    64'(mGrant));
      checkOutput("s_valid",     64'(s_valid),     64'(eValid));
      checkOutput("s_write",     64'(s_write),     64'(eValid && (eStrb != '0)));
      checkOutput("s_addr",      64'(s_addr),      64'(eAddr));
      checkOutput("s_wdata",     64'(s_wdata),     64'(eWdata));
      checkOutput("s_wstrb",     64'(s_wstrb),     64'(eStrb));
      checkOutput("req_ready",   64'(req_ready),   64'(eReady));
      checkOutput("req_rdata",   64'(req_rdata),   64'(eRdata));
      checkOutput("timeout_err", 64'(timeout_err), 64'(eTerr));
   endtask

   // Move the model to the next cycle: finish or continue the transaction, or grant round-robin.
   task automatic advanceModel();
      int idx;
      if (mBusy) begin
         if (!pending[mOwner]) begin
            mBusy = 1'b0;
         end else if (mCycle == mLat || mCycle == Tmo) begin
            pending[mOwner] = 1'b0;
            mBusy           = 1'b0;
         end else begin
            mCycle++;
         end
      end else if (pending != '0) begin
         for (int k = NumReq; k >= 1; k--) begin
            idx = (mLast + k) % NumReq;
            if (pending[idx]) mOwner = idx;
         end
         mLast  = mOwner;
         mGrant = mOwner;
         mBusy  = 1'b1;
         mCycle = 1;
         mLat   = $urandom_range(1, latMax);
      end
      for (int i = 0; i < NumReq; i++) begin
         if (!pending[i] && $urandom_range(0, 99) < reqPct) newRequest(i);
      end
   endtask

   task automatic cycleBody(input bit allowAbort);
      if (allowAbort && mBusy && pending[mOwner] && mCycle != mLat && mCycle != Tmo
          && $urandom_range(0, 19) == 0) begin
         pending[mOwner] = 1'b0;
      end
      applyStimulus();
      #1;
      expectCycle();
      advanceModel();
   endtask

   task automatic stepCycle(input bit allowAbort);
      @(negedge clk);
      cycleBody(allowAbort);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      pending   = '0;
      for (int i = 0; i < NumReq; i++) begin
         pAddr[i]  = '0;
         pWdata[i] = '0;
         pWstrb[i] = '0;
      end
      mBusy  = 1'b0;
      mOwner = 0;
      mLast  = NumReq - 1;
      mGrant = 0;
      mCycle = 0;
      mLat   = 1;
      reqPct = 40;
      latMax = 11;
      reset  = 1'b1;
      applyStimulus();

      @(negedge clk);
      #1;
      checkOutput("rst_busy",      64'(busy),        64'd0);
      checkOutput("rst_s_valid",   64'(s_valid),     64'd0);
      checkOutput("rst_req_ready", 64'(req_ready),   64'd0);
      checkOutput("rst_grant_id",  64'(grant_id),    64'd0);
      checkOutput("rst_req_rdata", 64'(req_rdata),   64'd0);
      checkOutput("rst_terr",      64'(timeout_err), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] random traffic with aborts");
      repeat (400) stepCycle(1'b1);

      $display("[TB] reset during BUSY");
      reqPct = 100;
      for (int n = 0; n < 50 && !mBusy; n++) stepCycle(1'b0);
      @(negedge clk);
      applyStimulus();
      #1;
      checkOutput("mid_busy", 64'(busy), 64'(mBusy));
      reset = 1'b1;
      #1;
      checkOutput("async_s_valid",   64'(s_valid),   64'd0);
      checkOutput("async_req_ready", 64'(req_ready), 64'd0);
      checkOutput("async_busy",      64'(busy),      64'd0);
      checkOutput("async_grant_id",  64'(grant_id),  64'd0);
      mBusy  = 1'b0;
      mLast  = NumReq - 1;
      mGrant = 0;
      for (int i = 0; i < NumReq; i++) begin
         if (!pending[i]) newRequest(i);
      end
      applyStimulus();
      @(negedge clk);
      reset = 1'b0;
      cycleBody(1'b0);
      stepCycle(1'b0);
      checkOutput("first_grant", 64'(grant_id), 64'd0);

      $display("[TB] all requesters continuous, single-cycle slave");
      latMax = 1;
      repeat (60) stepCycle(1'b0);

      $display("[TB] random traffic, long latencies");
      reqPct = 30;
      latMax = 12;
      repeat (300) stepCycle(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
